// File: rtl/training_pkg.sv
// Shared types and Q16.16 helpers for the training sample loader.
package training_pkg;

    localparam int unsigned FRAC_BITS = 16;
    localparam logic [31:0] FIX_ONE   = 32'h0001_0000;

    typedef enum logic [1:0] {
        FLD_IN0 = 2'd0,
        FLD_IN1 = 2'd1,
        FLD_TGT = 2'd2
    } field_e;

    typedef enum logic [1:0] {
        ST_EDIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // Exact Q8.8 -> Q16.16: sign-extend, then align the binary point.
    function automatic logic [31:0] q88_to_q1616(input logic [15:0] v);
        logic signed [31:0] w;
        w = 32'(signed'(v));
        return 32'(w <<< (FRAC_BITS - 8));
    endfunction

endpackage

// File: rtl/next_full_slot.sv
// Cyclic priority search: first set mask bit strictly after cur_i, wrapping (cur_i itself last).
module next_full_slot #(
    parameter  int unsigned N     = 4,
    localparam int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     mask_i,
    input  logic [IDX_W-1:0] cur_i,
    output logic [IDX_W-1:0] nxt_c,
    output logic             wrap_c
);

    always_comb begin
        logic found;
        found  = 1'b0;
        nxt_c  = cur_i;
        wrap_c = 1'b0;
        for (int unsigned k = 1; k <= N; k++) begin
            int unsigned idx;
            idx = (32'(cur_i) + k) % N;
            if (!found && mask_i[IDX_W'(idx)]) begin
                found = 1'b1;
                nxt_c = IDX_W'(idx);
            end
        end
        wrap_c = (nxt_c <= cur_i);
    end

endmodule

// File: rtl/training_sample_loader.sv
// Editable sample buffer streamed round-robin to the trainer over valid/ready.
module training_sample_loader
    import training_pkg::*;
#(
    parameter  int unsigned NUM_SAMPLES = 4,
    parameter  int unsigned VAL_W       = 32,
    parameter  int unsigned ENTRY_W     = 16,
    localparam int unsigned IDX_W       = $clog2(NUM_SAMPLES)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ENTRY_W-1:0]     wr_value,
    input  logic [1:0]             wr_field,
    input  logic [IDX_W-1:0]       wr_index,
    input  logic                   wr_strobe,
    input  logic                   clr_strobe,
    input  logic                   start_strobe,
    input  logic                   stop_strobe,
    output logic                   smp_valid,
    input  logic                   smp_ready,
    output logic [VAL_W-1:0]       smp_in0,
    output logic [VAL_W-1:0]       smp_in1,
    output logic [VAL_W-1:0]       smp_target,
    output logic [IDX_W-1:0]       smp_index,
    output logic [15:0]            epoch,
    output logic [NUM_SAMPLES-1:0] slot_full,
    output logic                   running,
    output logic                   err
);

    state_e                 state_q, state_d;
    logic [VAL_W-1:0]       in0_q [NUM_SAMPLES];
    logic [VAL_W-1:0]       in0_d [NUM_SAMPLES];
    logic [VAL_W-1:0]       in1_q [NUM_SAMPLES];
    logic [VAL_W-1:0]       in1_d [NUM_SAMPLES];
    logic [VAL_W-1:0]       tgt_q [NUM_SAMPLES];
    logic [VAL_W-1:0]       tgt_d [NUM_SAMPLES];
    logic [2:0]             mask_q [NUM_SAMPLES];
    logic [2:0]             mask_d [NUM_SAMPLES];
    logic [NUM_SAMPLES-1:0] full_q, full_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic                   valid_q, valid_d;
    logic [VAL_W-1:0]       o_in0_q, o_in0_d, o_in1_q, o_in1_d, o_tgt_q, o_tgt_d;
    logic [15:0]            epoch_q, epoch_d;
    logic                   running_q, running_d;
    logic                   err_q, err_d;

    logic [IDX_W-1:0]       nxt_idx, first_idx;
    logic                   nxt_wrap, first_wrap;
    logic [VAL_W-1:0]       wr_conv;
    logic                   xfer;

    next_full_slot #(.N(NUM_SAMPLES)) u_next (
        .mask_i (full_q),
        .cur_i  (ptr_q),
        .nxt_c  (nxt_idx),
        .wrap_c (nxt_wrap)
    );

    // Searching from the last slot yields the lowest full slot.
    next_full_slot #(.N(NUM_SAMPLES)) u_first (
        .mask_i (full_q),
        .cur_i  (IDX_W'(NUM_SAMPLES - 1)),
        .nxt_c  (first_idx),
        .wrap_c (first_wrap)
    );

    assign wr_conv = q88_to_q1616(wr_value);
    assign xfer    = valid_q && smp_ready;

    always_comb begin
        state_d = state_q;
        in0_d   = in0_q;
        in1_d   = in1_q;
        tgt_d   = tgt_q;
        mask_d  = mask_q;
        ptr_d   = ptr_q;
        valid_d = valid_q;
        o_in0_d = o_in0_q;
        o_in1_d = o_in1_q;
        o_tgt_d = o_tgt_q;
        epoch_d = epoch_q;
        err_d   = 1'b0;

        // Accepted sample: advance to the next full slot with no bubble.
        if (xfer) begin
            ptr_d   = nxt_idx;
            o_in0_d = in0_q[nxt_idx];
            o_in1_d = in1_q[nxt_idx];
            o_tgt_d = tgt_q[nxt_idx];
            if (nxt_wrap) epoch_d = epoch_q + 16'd1;
        end

        case (state_q)
            ST_EDIT: begin
                if (clr_strobe) begin
                    for (int i = 0; i < int'(NUM_SAMPLES); i++) mask_d[i] = 3'b000;
                end else if (wr_strobe) begin
                    case (wr_field)
                        FLD_IN0: begin in0_d[wr_index] = wr_conv; mask_d[wr_index][0] = 1'b1; end
                        FLD_IN1: begin in1_d[wr_index] = wr_conv; mask_d[wr_index][1] = 1'b1; end
                        FLD_TGT: begin tgt_d[wr_index] = wr_conv; mask_d[wr_index][2] = 1'b1; end
                        default: err_d = 1'b1;
                    endcase
                end
                // A clear in the same cycle empties the buffer, so start is rejected.
                if (start_strobe && !stop_strobe) begin
                    if ((full_q != '0) && !clr_strobe) begin
                        state_d = ST_RUN;
                        ptr_d   = first_idx;
                        valid_d = 1'b1;
                        o_in0_d = in0_q[first_idx];
                        o_in1_d = in1_q[first_idx];
                        o_tgt_d = tgt_q[first_idx];
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                err_d = wr_strobe || clr_strobe;
                if (stop_strobe) begin
                    if (valid_q && !smp_ready) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_EDIT;
                        valid_d = 1'b0;
                    end
                end
            end
            ST_DRAIN: begin
                err_d = wr_strobe || clr_strobe || (start_strobe && !stop_strobe);
                if (xfer) begin
                    state_d = ST_EDIT;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_EDIT;
                valid_d = 1'b0;
            end
        endcase

        for (int i = 0; i < int'(NUM_SAMPLES); i++) full_d[i] = &mask_d[i];
        running_d = (state_d != ST_EDIT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_EDIT;
            for (int i = 0; i < int'(NUM_SAMPLES); i++) begin
                in0_q[i]  <= '0;
                in1_q[i]  <= '0;
                tgt_q[i]  <= '0;
                mask_q[i] <= '0;
            end
            full_q    <= '0;
            ptr_q     <= '0;
            valid_q   <= 1'b0;
            o_in0_q   <= '0;
            o_in1_q   <= '0;
            o_tgt_q   <= '0;
            epoch_q   <= '0;
            running_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            in0_q     <= in0_d;
            in1_q     <= in1_d;
            tgt_q     <= tgt_d;
            mask_q    <= mask_d;
            full_q    <= full_d;
            ptr_q     <= ptr_d;
            valid_q   <= valid_d;
            o_in0_q   <= o_in0_d;
            o_in1_q   <= o_in1_d;
            o_tgt_q   <= o_tgt_d;
            epoch_q   <= epoch_d;
            running_q <= running_d;
            err_q     <= err_d;
        end
    end

    assign smp_valid  = valid_q;
    assign smp_in0    = o_in0_q;
    assign smp_in1    = o_in1_q;
    assign smp_target = o_tgt_q;
    assign smp_index  = ptr_q;
    assign epoch      = epoch_q;
    assign slot_full  = full_q;
    assign running    = running_q;
    assign err        = err_q;

endmodule

// File: tb/tb_training_sample_loader.sv
// Directed bench for training_sample_loader: editing, streaming, backpressure, drain, reset.
module tb_training_sample_loader;
    import training_pkg::FIX_ONE;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] wr_value = '0;
    logic [1:0]  wr_field = '0;
    logic [1:0]  wr_index = '0;
    logic        wr_strobe = 1'b0, clr_strobe = 1'b0, start_strobe = 1'b0, stop_strobe = 1'b0;
    logic        smp_ready = 1'b0;
    logic        smp_valid, running, err;
    logic [31:0] smp_in0, smp_in1, smp_target;
    logic [1:0]  smp_index;
    logic [15:0] epoch;
    logic [3:0]  slot_full;

    int tests = 0;
    int fails = 0;

    training_sample_loader dut (
        .clk(clk), .rst(rst),
        .wr_value(wr_value), .wr_field(wr_field), .wr_index(wr_index),
        .wr_strobe(wr_strobe), .clr_strobe(clr_strobe),
        .start_strobe(start_strobe), .stop_strobe(stop_strobe),
        .smp_valid(smp_valid), .smp_ready(smp_ready),
        .smp_in0(smp_in0), .smp_in1(smp_in1), .smp_target(smp_target),
        .smp_index(smp_index), .epoch(epoch), .slot_full(slot_full),
        .running(running), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] idx, input logic [1:0] fld, input logic [15:0] val);
        wr_index  = idx;
        wr_field  = fld;
        wr_value  = val;
        wr_strobe = 1'b1;
        tick();
        wr_strobe = 1'b0;
    endtask

    initial begin
        logic [31:0] held_in0;
        tick();
        tick();
        chk("rst_valid", 32'(smp_valid), 32'd0);
        chk("rst_epoch", 32'(epoch), 32'd0);
        chk("rst_full", 32'(slot_full), 32'd0);
        chk("rst_running", 32'(running), 32'd0);
        chk("rst_in0", smp_in0, 32'd0);
        rst = 1'b0;
        tick();

        // Start with nothing filled: one err pulse, stays in EDIT
        start_strobe = 1'b1; tick(); start_strobe = 1'b0;
        chk("empty_start_err", 32'(err), 32'd1);
        chk("empty_start_run", 32'(running), 32'd0);
        tick();
        chk("empty_start_err_clr", 32'(err), 32'd0);

        wr(2'd0, 2'd0, 16'h0100);
        wr(2'd0, 2'd1, 16'h0100);
        wr(2'd0, 2'd2, 16'h0000);
        chk("full_slot0", 32'(slot_full), 32'h1);
        wr(2'd2, 2'd0, 16'h0100);
        wr(2'd2, 2'd1, 16'h0000);
        wr(2'd2, 2'd2, 16'h0100);
        chk("full_0101", 32'(slot_full), 32'h5);
        wr(2'd1, 2'd3, 16'h1234);
        chk("rsvd_field_err", 32'(err), 32'd1);
        chk("rsvd_field_mask", 32'(slot_full), 32'h5);

        // Round-robin over slots 0 and 2, ready held high
        smp_ready = 1'b1;
        start_strobe = 1'b1; tick(); start_strobe = 1'b0;
        chk("run_running", 32'(running), 32'd1);
        for (int k = 0; k < 4; k++) begin
            chk("rr_valid", 32'(smp_valid), 32'd1);
            chk("rr_idx", 32'(smp_index), (k % 2 == 0) ? 32'd0 : 32'd2);
            chk("rr_in0", smp_in0, FIX_ONE);
            chk("rr_tgt", smp_target, (k % 2 == 0) ? 32'd0 : FIX_ONE);
            chk("rr_epoch", 32'(epoch), 32'(k / 2));
            tick();
        end

        // Backpressure: idx0 held for 5 cycles, then exactly one transfer
        smp_ready = 1'b0;
        held_in0 = smp_in0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_valid", 32'(smp_valid), 32'd1);
            chk("bp_idx", 32'(smp_index), 32'd0);
            chk("bp_in0", smp_in0, held_in0);
            chk("bp_epoch", 32'(epoch), 32'd2);
        end
        smp_ready = 1'b1; tick(); smp_ready = 1'b0;
        chk("bp_one_xfer", 32'(smp_index), 32'd2);
        tick();
        chk("bp_one_xfer_hold", 32'(smp_index), 32'd2);

        // Writes and clears in RUN are rejected and storage is frozen
        wr(2'd0, 2'd0, 16'h0200);
        chk("run_wr_err", 32'(err), 32'd1);
        clr_strobe = 1'b1; tick(); clr_strobe = 1'b0;
        chk("run_clr_err", 32'(err), 32'd1);
        chk("run_clr_full", 32'(slot_full), 32'h5);
        smp_ready = 1'b1; tick(); smp_ready = 1'b0;
        chk("frozen_idx", 32'(smp_index), 32'd0);
        chk("frozen_in0", smp_in0, FIX_ONE);
        chk("frozen_epoch", 32'(epoch), 32'd3);

        // Stop under backpressure drains the held sample
        stop_strobe = 1'b1; tick(); stop_strobe = 1'b0;
        chk("drain_valid", 32'(smp_valid), 32'd1);
        chk("drain_running", 32'(running), 32'd1);
        tick();
        chk("drain_hold_idx", 32'(smp_index), 32'd0);
        smp_ready = 1'b1; tick(); smp_ready = 1'b0;
        chk("drain_done_valid", 32'(smp_valid), 32'd0);
        chk("drain_done_running", 32'(running), 32'd0);
        chk("drain_epoch", 32'(epoch), 32'd3);

        // Negative conversion in slot 1
        wr(2'd1, 2'd0, 16'h0080);
        wr(2'd1, 2'd1, 16'h0000);
        wr(2'd1, 2'd2, 16'hFF80);
        chk("full_0111", 32'(slot_full), 32'h7);
        start_strobe = 1'b1; tick(); start_strobe = 1'b0;
        chk("neg_first_idx", 32'(smp_index), 32'd0);
        smp_ready = 1'b1; tick();
        chk("neg_idx", 32'(smp_index), 32'd1);
        chk("neg_tgt", smp_target, 32'hFFFF8000);
        chk("half_in0", smp_in0, 32'h00008000);
        tick();
        chk("neg_next_idx", 32'(smp_index), 32'd2);
        tick();
        chk("neg_wrap_epoch", 32'(epoch), 32'd4);

        // Stop coinciding with a transfer returns straight to EDIT
        stop_strobe = 1'b1; tick(); stop_strobe = 1'b0;
        chk("stop_xfer_valid", 32'(smp_valid), 32'd0);
        chk("stop_xfer_running", 32'(running), 32'd0);

        // start+stop together: stop wins, no err
        start_strobe = 1'b1; stop_strobe = 1'b1; tick();
        start_strobe = 1'b0; stop_strobe = 1'b0;
        chk("start_stop_err", 32'(err), 32'd0);
        chk("start_stop_running", 32'(running), 32'd0);

        // Asynchronous reset mid-RUN
        start_strobe = 1'b1; tick(); start_strobe = 1'b0;
        tick();
        chk("pre_rst_running", 32'(running), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_valid", 32'(smp_valid), 32'd0);
        chk("async_epoch", 32'(epoch), 32'd0);
        chk("async_full", 32'(slot_full), 32'd0);
        chk("async_running", 32'(running), 32'd0);
        tick();
        rst = 1'b0;
        start_strobe = 1'b1; tick(); start_strobe = 1'b0;
        chk("post_rst_start_err", 32'(err), 32'd1);
        chk("post_rst_running", 32'(running), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
